// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields back into a 32-bit instruction word.
// Two-stage valid/ready pipe: stage 1 looks up opcode/funct/format, stage 2 scatters imm and checks it.
module inst_encoder #(
    parameter bit CHECK_IMM = 1'b1,
    parameter bit ERR_ZERO  = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        clr_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [5:0]  in_code,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err
);
    localparam logic [2:0] T_ALU = 3'd0, T_LD = 3'd1, T_ST = 3'd2, T_BRC = 3'd3, T_JMP = 3'd4;
    localparam logic [5:0] C_ADD = 6'd0, C_SUB = 6'd1, C_SLL = 6'd2, C_SLT = 6'd3, C_SLTU = 6'd4,
                           C_XOR = 6'd5, C_SRL = 6'd6, C_SRA = 6'd7, C_OR = 6'd8, C_AND = 6'd9,
                           C_ADDI = 6'd10, C_SLTI = 6'd11, C_SLTIU = 6'd12, C_XORI = 6'd13,
                           C_ORI = 6'd14, C_ANDI = 6'd15, C_SLLI = 6'd16, C_SRLI = 6'd17,
                           C_SRAI = 6'd18, C_LUI = 6'd19, C_AUIPC = 6'd20, C_LB = 6'd21,
                           C_LH = 6'd22, C_LW = 6'd23, C_LBU = 6'd24, C_LHU = 6'd25, C_SB = 6'd26,
                           C_SH = 6'd27, C_SW = 6'd28, C_BEQ = 6'd29, C_BNE = 6'd30, C_BLT = 6'd31,
                           C_BGE = 6'd32, C_BLTU = 6'd33, C_BGEU = 6'd34, C_JALR = 6'd35,
                           C_JAL = 6'd36;

    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J} fmt_e;

    logic        s1_valid_q, s2_valid_q, s1_err_q, out_err_q;
    logic [6:0]  s1_op_q, s1_f7_q;
    logic [2:0]  s1_f3_q;
    fmt_e        s1_fmt_q;
    logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [31:0] s1_imm_q, out_inst_q;

    logic [6:0]  op_d, f7_d;
    logic [2:0]  f3_d, cls_d;
    fmt_e        fmt_d;
    logic        bad_d, err1_d, bad_imm, err2_d;
    logic [31:0] enc_d, inst2_d;
    logic        s2_take;

    // True when v survives sign-extension from its low n bits.
    function automatic logic fits(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = $signed(v) >>> (n - 1);
        return t == 32'h0 || t == 32'hFFFF_FFFF;
    endfunction

    assign s2_take   = !s2_valid_q || out_ready;
    assign in_ready  = clr_in || !s1_valid_q || s2_take;
    assign out_valid = s2_valid_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;

    always_comb begin
        f7_d = (in_code == C_SUB || in_code == C_SRA || in_code == C_SRAI) ? 7'h20 : 7'h00;
        case (in_code)
            C_ADD, C_SUB, C_ADDI, C_LB, C_SB, C_BEQ, C_JALR: f3_d = 3'd0;
            C_SLL, C_SLLI, C_LH, C_SH, C_BNE:                f3_d = 3'd1;
            C_SLT, C_SLTI, C_LW, C_SW:                       f3_d = 3'd2;
            C_SLTU, C_SLTIU:                                 f3_d = 3'd3;
            C_XOR, C_XORI, C_LBU, C_BLT:                     f3_d = 3'd4;
            C_SRL, C_SRA, C_SRLI, C_SRAI, C_LHU, C_BGE:      f3_d = 3'd5;
            C_OR, C_ORI, C_BLTU:                             f3_d = 3'd6;
            C_AND, C_ANDI, C_BGEU:                           f3_d = 3'd7;
            default:                                         f3_d = 3'd0;
        endcase
        bad_d = 1'b0;
        op_d  = 7'h33;
        fmt_d = F_R;
        cls_d = T_ALU;
        if (in_code <= C_AND) begin
            op_d = 7'h33;
        end else if (in_code <= C_ANDI) begin
            op_d = 7'h13; fmt_d = F_I;
        end else if (in_code <= C_SRAI) begin
            op_d = 7'h13; fmt_d = F_SH;
        end else if (in_code == C_LUI) begin
            op_d = 7'h37; fmt_d = F_U;
        end else if (in_code == C_AUIPC) begin
            op_d = 7'h17; fmt_d = F_U;
        end else if (in_code <= C_LHU) begin
            op_d = 7'h03; fmt_d = F_I; cls_d = T_LD;
        end else if (in_code <= C_SW) begin
            op_d = 7'h23; fmt_d = F_S; cls_d = T_ST;
        end else if (in_code <= C_BGEU) begin
            op_d = 7'h63; fmt_d = F_B; cls_d = T_BRC;
        end else if (in_code == C_JALR) begin
            op_d = 7'h67; fmt_d = F_I; cls_d = T_JMP;
        end else if (in_code == C_JAL) begin
            op_d = 7'h6F; fmt_d = F_J; cls_d = T_JMP;
        end else begin
            bad_d = 1'b1;
        end
        err1_d = bad_d || cls_d != in_type;
    end

    always_comb begin
        enc_d   = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        bad_imm = 1'b0;
        case (s1_fmt_q)
            F_I: begin
                enc_d   = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
                bad_imm = !fits(s1_imm_q, 12);
            end
            F_SH: begin
                enc_d   = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
                bad_imm = |s1_imm_q[31:5];
            end
            F_S: begin
                enc_d   = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
                bad_imm = !fits(s1_imm_q, 12);
            end
            F_B: begin
                enc_d   = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                           s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
                bad_imm = !fits(s1_imm_q, 13) || s1_imm_q[0];
            end
            F_U: begin
                enc_d   = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
                bad_imm = |s1_imm_q[11:0];
            end
            F_J: begin
                enc_d   = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q, s1_op_q};
                bad_imm = !fits(s1_imm_q, 21) || s1_imm_q[0];
            end
            default: ;
        endcase
        err2_d  = s1_err_q || (CHECK_IMM && bad_imm);
        inst2_d = (ERR_ZERO && err2_d) ? 32'h0 : enc_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_op_q    <= 7'h0;
            s1_f7_q    <= 7'h0;
            s1_f3_q    <= 3'h0;
            s1_fmt_q   <= F_R;
            s1_rd_q    <= 5'h0;
            s1_rs1_q   <= 5'h0;
            s1_rs2_q   <= 5'h0;
            s1_imm_q   <= 32'h0;
            out_inst_q <= 32'h0;
            out_err_q  <= 1'b0;
        end else begin
            // Flush beats any simultaneous accept or advance.
            if (clr_in) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                if (s2_take) s2_valid_q <= s1_valid_q;
                if (in_ready) s1_valid_q <= in_valid;
            end
            if (!clr_in && in_valid && in_ready) begin
                s1_err_q <= err1_d;
                s1_op_q  <= op_d;
                s1_f7_q  <= f7_d;
                s1_f3_q  <= f3_d;
                s1_fmt_q <= fmt_d;
                s1_rd_q  <= in_rd;
                s1_rs1_q <= in_rs1;
                s1_rs2_q <= in_rs2;
                s1_imm_q <= in_imm;
            end
            if (!clr_in && s2_take && s1_valid_q) begin
                out_inst_q <= inst2_d;
                out_err_q  <= err2_d;
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed vectors plus a random stream checked by a reference decoder and scoreboard.
module tb_inst_encoder;
    localparam int T_ALU = 0, T_LD = 1, T_ST = 2, T_BRC = 3, T_JMP = 4;
    localparam int C_ADD = 0, C_SUB = 1, C_SLL = 2, C_SLT = 3, C_SLTU = 4, C_XOR = 5, C_SRL = 6,
                   C_SRA = 7, C_OR = 8, C_AND = 9, C_ADDI = 10, C_SLTI = 11, C_SLTIU = 12,
                   C_XORI = 13, C_ORI = 14, C_ANDI = 15, C_SLLI = 16, C_SRLI = 17, C_SRAI = 18,
                   C_LUI = 19, C_AUIPC = 20, C_LB = 21, C_LH = 22, C_LW = 23, C_LBU = 24,
                   C_LHU = 25, C_SB = 26, C_SH = 27, C_SW = 28, C_BEQ = 29, C_BNE = 30,
                   C_BLT = 31, C_BGE = 32, C_BLTU = 33, C_BGEU = 34, C_JALR = 35, C_JAL = 36;
    localparam int BAD = 63;
    localparam int NRAND = 10000;

    typedef struct packed {
        logic [5:0]  code;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fld_t;
    typedef struct {
        fld_t f;
        logic err;
    } item_t;

    logic        clk_in = 1'b0, rst_n_in = 1'b0, clr_in = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_err;
    logic [2:0]  in_type = 3'd0;
    logic [5:0]  in_code = 6'd0;
    logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0, out_inst;
    int          checks = 0, errors = 0;
    item_t       q[$];

    inst_encoder #(.CHECK_IMM(1'b1), .ERR_ZERO(1'b1)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .clr_in(clr_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_code(in_code),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int cls_of(input int c);
        if (c <= C_AUIPC) return T_ALU;
        if (c <= C_LHU) return T_LD;
        if (c <= C_SW) return T_ST;
        if (c <= C_BGEU) return T_BRC;
        if (c <= C_JAL) return T_JMP;
        return 7;
    endfunction

    // 0 R, 1 I, 2 shift, 3 S, 4 B, 5 U, 6 J, 7 unknown
    function automatic int fmt_of(input int c);
        if (c <= C_AND) return 0;
        if (c <= C_ANDI) return 1;
        if (c <= C_SRAI) return 2;
        if (c <= C_AUIPC) return 5;
        if (c <= C_LHU) return 1;
        if (c <= C_SW) return 3;
        if (c <= C_BGEU) return 4;
        if (c == C_JALR) return 1;
        if (c == C_JAL) return 6;
        return 7;
    endfunction

    function automatic logic exp_err(input int typ, input int code, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if (code > C_JAL || typ != cls_of(code)) return 1'b1;
        case (fmt_of(code))
            1, 3: return s < -2048 || s > 2047;
            2: return imm > 32'd31;
            4: return s < -4096 || s > 4095 || imm[0];
            5: return imm[11:0] != 12'd0;
            6: return s < -1048576 || s > 1048575 || imm[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic fld_t decode(input logic [31:0] w);
        fld_t f;
        logic [2:0] f3;
        logic [6:0] f7;
        int c;
        f3 = w[14:12];
        f7 = w[31:25];
        c = BAD;
        f.rd = w[11:7];
        f.rs1 = w[19:15];
        f.rs2 = w[24:20];
        f.imm = {{20{w[31]}}, w[31:20]};
        case (w[6:0])
            7'h33: case (f3)
                0: c = f7 == 0 ? C_ADD : f7 == 7'h20 ? C_SUB : BAD;
                1: c = f7 == 0 ? C_SLL : BAD;
                2: c = f7 == 0 ? C_SLT : BAD;
                3: c = f7 == 0 ? C_SLTU : BAD;
                4: c = f7 == 0 ? C_XOR : BAD;
                5: c = f7 == 0 ? C_SRL : f7 == 7'h20 ? C_SRA : BAD;
                6: c = f7 == 0 ? C_OR : BAD;
                default: c = f7 == 0 ? C_AND : BAD;
            endcase
            7'h13: begin
                case (f3)
                    0: c = C_ADDI;
                    1: c = f7 == 0 ? C_SLLI : BAD;
                    2: c = C_SLTI;
                    3: c = C_SLTIU;
                    4: c = C_XORI;
                    5: c = f7 == 0 ? C_SRLI : f7 == 7'h20 ? C_SRAI : BAD;
                    6: c = C_ORI;
                    default: c = C_ANDI;
                endcase
                if (f3 == 1 || f3 == 5) f.imm = {27'd0, w[24:20]};
            end
            7'h03: c = f3 == 0 ? C_LB : f3 == 1 ? C_LH : f3 == 2 ? C_LW : f3 == 4 ? C_LBU : f3 == 5 ? C_LHU : BAD;
            7'h23: begin
                c = f3 == 0 ? C_SB : f3 == 1 ? C_SH : f3 == 2 ? C_SW : BAD;
                f.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'h63: begin
                c = f3 == 0 ? C_BEQ : f3 == 1 ? C_BNE : f3 == 4 ? C_BLT : f3 == 5 ? C_BGE :
                    f3 == 6 ? C_BLTU : f3 == 7 ? C_BGEU : BAD;
                f.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h67: c = f3 == 0 ? C_JALR : BAD;
            7'h6F: begin
                c = C_JAL;
                f.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h37, 7'h17: begin
                c = w[6:0] == 7'h37 ? C_LUI : C_AUIPC;
                f.imm = {w[31:12], 12'd0};
            end
            default: c = BAD;
        endcase
        f.code = 6'(c);
        return f;
    endfunction

    // Zero the fields a format does not carry so only encoded ones are compared.
    function automatic fld_t used(input fld_t f);
        case (fmt_of(int'(f.code)))
            0: f.imm = 32'd0;
            1, 2: f.rs2 = 5'd0;
            3, 4: f.rd = 5'd0;
            5, 6: begin f.rs1 = 5'd0; f.rs2 = 5'd0; end
            default: ;
        endcase
        return f;
    endfunction

    task automatic set_fields(input int typ, input int code, input int rd, input int rs1, input int rs2,
                              input logic [31:0] imm);
        in_type = 3'(typ);
        in_code = 6'(code);
        in_rd = 5'(rd);
        in_rs1 = 5'(rs1);
        in_rs2 = 5'(rs2);
        in_imm = imm;
    endtask

    task automatic rand_fields();
        int c;
        c = $urandom_range(0, 99) < 96 ? int'($urandom_range(0, C_JAL)) : int'($urandom_range(37, 63));
        in_code = 6'(c);
        in_type = $urandom_range(0, 99) < 95 ? 3'(cls_of(c)) : 3'($urandom_range(0, 7));
        in_rd = 5'($urandom);
        in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom);
        if ($urandom_range(0, 9) == 0) in_imm = $urandom;
        else case (fmt_of(c))
            1, 3: in_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            2: in_imm = 32'($urandom_range(0, 31));
            4: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096) & ~32'd1;
            5: in_imm = $urandom & 32'hFFFF_F000;
            6: in_imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & ~32'd1;
            default: in_imm = $urandom;
        endcase
    endtask

    // One word into an empty pipe with out_ready high; result must show exactly two edges later.
    task automatic directed(input string tag, input int typ, input int code, input int rd, input int rs1,
                            input int rs2, input logic [31:0] imm, input logic err, input logic [31:0] inst);
        @(posedge clk_in);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_fields(typ, code, rd, rs1, rs2, imm);
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
        #4;
        check({tag, "_lat"}, out_valid, 0);
        @(posedge clk_in);
        #5;
        check({tag, "_v"}, out_valid, 1);
        check(tag, out_inst, inst);
        check({tag, "_e"}, out_err, err);
    endtask

    function automatic logic [31:0] bp_word(input int i);
        return (32'(i) << 20) | (32'(i) << 15) | (32'(i + 1) << 7) | 32'h13;
    endfunction

    initial begin
        #1;
        check("rst_ov", out_valid, 0);
        check("rst_inst", out_inst, 0);
        check("rst_err", out_err, 0);
        #11 rst_n_in = 1'b1;
        #1 check("rst_rdy", in_ready, 1);

        directed("add", T_ALU, C_ADD, 1, 2, 3, 32'd0, 1'b0, 32'h003100B3);
        directed("addi", T_ALU, C_ADDI, 5, 0, 0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293);
        directed("srai", T_ALU, C_SRAI, 1, 2, 0, 32'd3, 1'b0, 32'h40315093);
        directed("beq", T_BRC, C_BEQ, 0, 1, 2, -32'sd4, 1'b0, 32'hFE208EE3);
        directed("jal", T_JMP, C_JAL, 1, 0, 0, 32'd8, 1'b0, 32'h008000EF);
        directed("lui", T_ALU, C_LUI, 1, 0, 0, 32'h12345000, 1'b0, 32'h123450B7);
        directed("addi_max", T_ALU, C_ADDI, 1, 0, 0, 32'd2047, 1'b0, 32'h7FF00093);
        directed("addi_min", T_ALU, C_ADDI, 1, 0, 0, -32'sd2048, 1'b0, 32'h80000093);
        directed("addi_ovf", T_ALU, C_ADDI, 1, 0, 0, 32'd2048, 1'b1, 32'h0);
        directed("beq_odd", T_BRC, C_BEQ, 0, 1, 2, 32'd3, 1'b1, 32'h0);
        directed("sw_as_ld", T_LD, C_SW, 0, 1, 2, 32'd0, 1'b1, 32'h0);
        directed("slli_32", T_ALU, C_SLLI, 1, 2, 0, 32'd32, 1'b1, 32'h0);
        directed("lui_low", T_ALU, C_LUI, 1, 0, 0, 32'h12345001, 1'b1, 32'h0);

        begin : bp
            int sent, got;
            logic stalled;
            logic [31:0] held;
            sent = 0;
            got = 0;
            stalled = 1'b0;
            held = 32'd0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk_in);
                #1;
                in_valid = sent < 8;
                set_fields(T_ALU, C_ADDI, sent + 1, sent, int'($urandom_range(0, 31)), 32'(sent));
                out_ready = !(c >= 4 && c <= 6);
                #4;
                if (stalled) begin
                    check("bp_hold_v", out_valid, 1);
                    check("bp_hold", out_inst, held);
                end
                if (c == 5 || c == 6) check("bp_rdy", in_ready, 0);
                if (in_valid && in_ready) sent++;
                if (out_valid && out_ready) begin
                    check("bp_word", out_inst, bp_word(got));
                    got++;
                end
                stalled = out_valid && !out_ready;
                held = out_inst;
            end
            in_valid = 1'b0;
            check("bp_cnt", got, 8);
            check("bp_tail", out_valid, 0);
        end

        @(posedge clk_in);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_fields(T_ALU, C_ADDI, 1, 1, 0, 32'd1);
        @(posedge clk_in);
        #1;
        set_fields(T_ALU, C_ADDI, 2, 2, 0, 32'd2);
        @(posedge clk_in);
        #1;
        set_fields(T_ALU, C_ADDI, 3, 3, 0, 32'd3);
        clr_in = 1'b1;
        #4;
        check("clr_full", out_valid, 1);
        check("clr_rdy", in_ready, 1);
        @(posedge clk_in);
        #1;
        clr_in = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #4;
        check("clr_ov", out_valid, 0);
        @(posedge clk_in);
        #5;
        check("clr_ov2", out_valid, 0);
        directed("clr_next", T_ALU, C_ADD, 1, 2, 3, 32'd0, 1'b0, 32'h003100B3);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            #1;
            in_valid = 1'b1;
            set_fields(T_ALU, C_ADDI, i + 4, i, 0, 32'(i + 7));
        end
        @(posedge clk_in);
        #2;
        check("rstm_pre", out_valid, 1);
        rst_n_in = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rstm_ov", out_valid, 0);
        check("rstm_inst", out_inst, 0);
        check("rstm_err", out_err, 0);
        #3 rst_n_in = 1'b1;

        begin : rnd
            int sent, got, cyc;
            item_t e;
            fld_t d;
            sent = 0;
            got = 0;
            cyc = 0;
            q.delete();
            while ((sent < NRAND || q.size() > 0) && cyc < 80000) begin
                @(posedge clk_in);
                #1;
                cyc++;
                in_valid = sent < NRAND && $urandom_range(0, 3) != 0;
                rand_fields();
                out_ready = sent >= NRAND || $urandom_range(0, 3) != 0;
                #4;
                if (in_valid && in_ready) begin
                    e.f = '{code: in_code, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
                    e.err = exp_err(int'(in_type), int'(in_code), in_imm);
                    q.push_back(e);
                    sent++;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) check("r_spurious", out_inst, 64'h1_0000_0000);
                    else begin
                        e = q.pop_front();
                        got++;
                        check("r_err", out_err, e.err);
                        if (e.err) check("r_zero", out_inst, 0);
                        else begin
                            d = decode(out_inst);
                            check("r_fields", used(d), used(e.f));
                        end
                    end
                end
            end
            in_valid = 1'b0;
            check("r_drain", q.size(), 0);
            check("r_cnt", got, NRAND);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
